// File: rtl/fifo_rd_arbiter.sv
// Read-side controller for the async FIFO: read pointer, empty/almost-empty flags, round-robin burst arbiter.
// Optional macro FIFO_RD_LEVEL_EN registers the read-domain fill level on rlevel (tied to 0 otherwise).
module fifo_rd_arbiter #(
  parameter int ADDR     = 3,
  parameter int NREQ     = 2,
  parameter int BURST    = 4,
  parameter int AE_LEVEL = 1
) (
  input  logic            rclk,
  input  logic            rrst_n,
  input  logic [ADDR:0]   rq2_wptr,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            rinc,
  output logic [ADDR-1:0] raddr,
  output logic [ADDR:0]   rptr,
  output logic            rempty,
  output logic            raempty,
  output logic [ADDR:0]   rlevel
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BURST_C  = CW'(BURST);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [ADDR:0] AE_C     = (ADDR + 1)'(AE_LEVEL);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_reg, state_next;
  logic [IW-1:0]  rr_last_reg, rr_last_next;
  logic [CW-1:0]  burst_cnt_reg, burst_cnt_next;
  logic [ADDR:0]  rbin_reg, rbin_next, rgray_next;
  logic [ADDR:0]  wbin, lvl;
  logic [IW-1:0]  sel, sel_hi, sel_lo;
  logic           hit_hi, hit_lo;

  // Gray-to-binary of the synchronized write pointer
  for (genvar gi = 0; gi <= ADDR; gi++) begin : g_g2b
    assign wbin[gi] = ^rq2_wptr[ADDR:gi];
  end

  assign rinc       = |gnt;
  assign raddr      = rbin_reg[ADDR-1:0];
  assign rbin_next  = rbin_reg + {{ADDR{1'b0}}, rinc};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign lvl        = wbin - rbin_next;

  // Round-robin pick: lowest requester above rr_last, else lowest overall
  always_comb begin
    sel_hi = '0;
    sel_lo = '0;
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_lo = IW'(i);
        hit_lo = 1'b1;
        if (IW'(i) > rr_last_reg) begin
          sel_hi = IW'(i);
          hit_hi = 1'b1;
        end
      end
    end
    sel = hit_hi ? sel_hi : sel_lo;
  end

  // rr_last doubles as the current owner while in GRANT
  always_comb begin
    gnt            = '0;
    state_next     = state_reg;
    rr_last_next   = rr_last_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (!rempty && hit_lo) begin
          gnt[sel]       = 1'b1;
          rr_last_next   = sel;
          burst_cnt_next = ONE_C;
          state_next     = (ONE_C >= BURST_C) ? IDLE : GRANT;
        end
      end
      GRANT: begin
        if (req[rr_last_reg] && !rempty && (burst_cnt_reg < BURST_C)) begin
          gnt[rr_last_reg] = 1'b1;
          burst_cnt_next   = burst_cnt_reg + ONE_C;
          if (burst_cnt_next >= BURST_C) begin
            state_next = IDLE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_reg     <= IDLE;
      rr_last_reg   <= IW'(NREQ - 1);
      burst_cnt_reg <= '0;
      rbin_reg      <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      raempty       <= 1'b1;
    end else begin
      state_reg     <= state_next;
      rr_last_reg   <= rr_last_next;
      burst_cnt_reg <= burst_cnt_next;
      rbin_reg      <= rbin_next;
      rptr          <= rgray_next;
      rempty        <= (rgray_next == rq2_wptr);
      raempty       <= (lvl <= AE_C);
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel <= '0;
    end else begin
      rlevel <= lvl;
    end
  end
`else
  assign rlevel = '0;
`endif

endmodule
